// File: rtl/dist_sort_pkg.sv
// Shared types and constants for the dist_sort scheduler slice.
package dist_sort_pkg;
   localparam int VEC_W       = 64;
   localparam int BANK_DEPTH  = 8;
   localparam int ADDR_W      = 3;
   localparam int PIPE_STAGES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Tag width for a requester index; never narrower than one bit.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/dist_sort_sched_if.sv
// Requester / dist_sort / response bus of the scheduler.
// master: requesters plus the dist_sort engine; slave: the scheduler.
interface dist_sort_sched_if
   import dist_sort_pkg::*;
#(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*VEC_W-1:0] req_query;
   logic                     ds_in_valid;
   logic [VEC_W-1:0]         ds_query;
   logic [VEC_W-1:0]         ds_search_0, ds_search_1, ds_search_2, ds_search_3;
   logic [VEC_W-1:0]         ds_search_4, ds_search_5, ds_search_6, ds_search_7;
   logic                     ds_out_valid;
   logic [ADDR_W-1:0]        ds_addr_1st;
   logic [ADDR_W-1:0]        ds_addr_2nd;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [ADDR_W-1:0]        rsp_addr_1st;
   logic [ADDR_W-1:0]        rsp_addr_2nd;

   modport master (
      output req_valid, req_query, ds_out_valid, ds_addr_1st, ds_addr_2nd,
      input  req_ready, ds_in_valid, ds_query,
             ds_search_0, ds_search_1, ds_search_2, ds_search_3,
             ds_search_4, ds_search_5, ds_search_6, ds_search_7,
             rsp_valid, rsp_addr_1st, rsp_addr_2nd
   );

   modport slave (
      input  req_valid, req_query, ds_out_valid, ds_addr_1st, ds_addr_2nd,
      output req_ready, ds_in_valid, ds_query,
             ds_search_0, ds_search_1, ds_search_2, ds_search_3,
             ds_search_4, ds_search_5, ds_search_6, ds_search_7,
             rsp_valid, rsp_addr_1st, rsp_addr_2nd
   );
endinterface

// File: rtl/dist_sort_tag_fifo.sv
// In-flight tag FIFO: remembers which requester issued each query so results
// can be routed back in issue order. DEPTH must be a power of two.
module dist_sort_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_push     = i_push & ~o_full;
   assign w_pop      = i_pop & ~o_empty;

   // Storage needs no reset: only entries below the count are ever read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // Pointers wrap by natural overflow; count is unchanged on push+pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/dist_sort_sched.sv
// Round-robin query scheduler in front of a pipelined dist_sort engine.
// Optional macro DIST_SORT_SCHED_PERF_EN adds saturating issue/complete counters.
//
// state    | meaning
// ST_IDLE  | stopped; search bank may be written
// ST_RUN   | grants queries while the tag FIFO has room
// ST_DRAIN | no new grants; waits for in-flight results to return
module dist_sort_sched
   import dist_sort_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic              sv_wr_en,
   input  logic [ADDR_W-1:0] sv_wr_addr,
   input  logic [VEC_W-1:0]  sv_wr_data,
   dist_sort_sched_if.slave  bus,
   output logic              busy,
   output logic [1:0]        err_sticky,
   output logic [31:0]       issued_cnt,
   output logic [31:0]       completed_cnt
);
   localparam int TAG_W = tag_width(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t              r_state;
   logic [VEC_W-1:0]    r_bank   [BANK_DEPTH];
   logic [VEC_W-1:0]    r_search [BANK_DEPTH];
   logic [TAG_W-1:0]    r_rr_ptr;
   logic                r_ds_in_valid;
   logic [VEC_W-1:0]    r_ds_query;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [ADDR_W-1:0]   r_rsp_addr_1st;
   logic [ADDR_W-1:0]   r_rsp_addr_2nd;
   logic [1:0]          r_err;

   logic                w_found;
   logic [TAG_W-1:0]    w_win;
   logic [TAG_W-1:0]    w_idx;
   logic                w_hs;
   logic                w_route;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [TAG_W-1:0]    w_pop_tag;
   logic [CNT_W-1:0]    w_fifo_count;

   // Round-robin search starting at the pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = TAG_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && bus.req_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_hs          = (r_state == ST_RUN) && !w_fifo_full && w_found;
   assign bus.req_ready = w_hs ? (NUM_REQ'(1) << w_win) : '0;
   assign w_route       = bus.ds_out_valid && !w_fifo_empty;

   dist_sort_tag_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TAG_W)
   ) u_tag_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_hs),
      .i_push_data (w_win),
      .i_pop       (bus.ds_out_valid),
      .o_pop_data  (w_pop_tag),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   // Control FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (cfg_start) r_state <= ST_RUN;
            ST_RUN:   if (cfg_stop)  r_state <= ST_DRAIN;
            ST_DRAIN: if (w_fifo_count == '0) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Search bank, writable only while idle, and its registered copy to dist_sort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < BANK_DEPTH; k++) begin
            r_bank[k]   <= '0;
            r_search[k] <= '0;
         end
      end else begin
         if (sv_wr_en && r_state == ST_IDLE) r_bank[sv_wr_addr] <= sv_wr_data;
         for (int k = 0; k < BANK_DEPTH; k++) r_search[k] <= r_bank[k];
      end
   end

   // Sticky errors: dropped bank write, result with nothing in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= '0;
      end else begin
         if (sv_wr_en && r_state != ST_IDLE)    r_err[0] <= 1'b1;
         if (bus.ds_out_valid && w_fifo_empty) r_err[1] <= 1'b1;
      end
   end

   // Pointer moves past the winner only when a grant is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= '0;
      end else if (w_hs) begin
         r_rr_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
      end
   end

   // Issue the granted query to dist_sort one cycle after the handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ds_in_valid <= 1'b0;
         r_ds_query    <= '0;
      end else begin
         r_ds_in_valid <= w_hs;
         if (w_hs) r_ds_query <= bus.req_query[w_win*VEC_W +: VEC_W];
      end
   end

   // Route each result to the requester at the head of the tag FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp_valid    <= '0;
         r_rsp_addr_1st <= '0;
         r_rsp_addr_2nd <= '0;
      end else begin
         r_rsp_valid <= w_route ? (NUM_REQ'(1) << w_pop_tag) : '0;
         if (w_route) begin
            r_rsp_addr_1st <= bus.ds_addr_1st;
            r_rsp_addr_2nd <= bus.ds_addr_2nd;
         end
      end
   end

   assign bus.ds_in_valid  = r_ds_in_valid;
   assign bus.ds_query     = r_ds_query;
   assign bus.ds_search_0  = r_search[0];
   assign bus.ds_search_1  = r_search[1];
   assign bus.ds_search_2  = r_search[2];
   assign bus.ds_search_3  = r_search[3];
   assign bus.ds_search_4  = r_search[4];
   assign bus.ds_search_5  = r_search[5];
   assign bus.ds_search_6  = r_search[6];
   assign bus.ds_search_7  = r_search[7];
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_addr_1st = r_rsp_addr_1st;
   assign bus.rsp_addr_2nd = r_rsp_addr_2nd;
   assign busy             = (r_state != ST_IDLE);
   assign err_sticky       = r_err;

`ifdef DIST_SORT_SCHED_PERF_EN
   logic [31:0] r_issued;
   logic [31:0] r_completed;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_issued    <= '0;
         r_completed <= '0;
      end else begin
         if (w_hs && r_issued != '1)       r_issued    <= r_issued + 32'd1;
         if (w_route && r_completed != '1) r_completed <= r_completed + 32'd1;
      end
   end

   assign issued_cnt    = r_issued;
   assign completed_cnt = r_completed;
`else
   assign issued_cnt    = '0;
   assign completed_cnt = '0;
`endif
endmodule

// File: tb/tb_dist_sort_sched.sv
// Directed bench for dist_sort_sched with a fixed-latency dist_sort stub.
module tb_dist_sort_sched;
   import dist_sort_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start, cfg_stop, sv_wr_en;
   logic [2:0]  sv_wr_addr;
   logic [63:0] sv_wr_data;
   logic        busy;
   logic [1:0]  err_sticky;
   logic [31:0] issued_cnt, completed_cnt;

   logic        stub_en;
   logic        man_ov;
   logic [2:0]  man_a1, man_a2;
   logic [PIPE_STAGES-1:0] r_pipe;
   logic [63:0] w_search [8];

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [63:0] Q0 = 64'hA0A0_1111_2222_3333;
   localparam logic [63:0] Q1 = 64'hB1B1_4444_5555_6666;
`ifdef DIST_SORT_SCHED_PERF_EN
   localparam logic [31:0] EXP_ISSUED = 32'd15;
   localparam logic [31:0] EXP_DONE   = 32'd15;
`else
   localparam logic [31:0] EXP_ISSUED = 32'd0;
   localparam logic [31:0] EXP_DONE   = 32'd0;
`endif

   dist_sort_sched_if #(.NUM_REQ(2)) bus ();

   dist_sort_sched #(.NUM_REQ(2), .FIFO_DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_stop      (cfg_stop),
      .sv_wr_en      (sv_wr_en),
      .sv_wr_addr    (sv_wr_addr),
      .sv_wr_data    (sv_wr_data),
      .bus           (bus),
      .busy          (busy),
      .err_sticky    (err_sticky),
      .issued_cnt    (issued_cnt),
      .completed_cnt (completed_cnt)
   );

   always #5 clk = ~clk;

   // dist_sort stub: result PIPE_STAGES cycles after each ds_in_valid.
   always @(posedge clk or negedge rst) begin
      if (!rst) r_pipe <= '0;
      else      r_pipe <= {r_pipe[PIPE_STAGES-2:0], bus.ds_in_valid};
   end

   assign bus.ds_out_valid = (stub_en & r_pipe[PIPE_STAGES-1]) | man_ov;
   assign bus.ds_addr_1st  = man_ov ? man_a1 : 3'b010;
   assign bus.ds_addr_2nd  = man_ov ? man_a2 : 3'b101;

   assign w_search[0] = bus.ds_search_0;
   assign w_search[1] = bus.ds_search_1;
   assign w_search[2] = bus.ds_search_2;
   assign w_search[3] = bus.ds_search_3;
   assign w_search[4] = bus.ds_search_4;
   assign w_search[5] = bus.ds_search_5;
   assign w_search[6] = bus.ds_search_6;
   assign w_search[7] = bus.ds_search_7;

   task automatic test_reset;
      rst = 1'b0; cfg_start = 0; cfg_stop = 0; sv_wr_en = 0; sv_wr_addr = 0;
      sv_wr_data = 0; stub_en = 0; man_ov = 0; man_a1 = 0; man_a2 = 0;
      bus.req_valid = 2'b11; bus.req_query = {Q1, Q0};
      repeat (2) @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (err_sticky !== 2'b00) $display("FAIL reset_err: got %b want 00", err_sticky); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", bus.req_ready); else pass_cnt++;
      total_cnt++; if (bus.ds_in_valid !== 1'b0) $display("FAIL reset_in_valid: got %b want 0", bus.ds_in_valid); else pass_cnt++;
      total_cnt++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); else pass_cnt++;
      total_cnt++; if (bus.ds_search_7 !== 64'd0) $display("FAIL reset_search7: got %h want 0", bus.ds_search_7); else pass_cnt++;
      total_cnt++; if (issued_cnt !== 32'd0) $display("FAIL reset_issued: got %0d want 0", issued_cnt); else pass_cnt++;
      bus.req_valid = 2'b00;
      rst = 1'b1;
   endtask

   task automatic test_bank;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         sv_wr_en = 1'b1; sv_wr_addr = 3'(k); sv_wr_data = 64'(k);
      end
      @(negedge clk);
      sv_wr_en = 1'b0; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         total_cnt++;
         if (w_search[k] !== 64'(k)) $display("FAIL bank_search%0d: got %h want %h", k, w_search[k], 64'(k));
         else pass_cnt++;
      end
      total_cnt++; if (busy !== 1'b1) $display("FAIL bank_busy: got %b want 1", busy); else pass_cnt++;
      total_cnt++; if (err_sticky !== 2'b00) $display("FAIL bank_err: got %b want 00", err_sticky); else pass_cnt++;
   endtask

   // Both requesters valid for 6 cycles; stub answers in order.
   task automatic test_rr_and_route;
      logic       exp_in;
      logic [1:0] exp_rsp, exp_rdy;
      logic [63:0] exp_q;
      int g;
      stub_en = 1'b1;
      for (int t = 0; t < PIPE_STAGES + 10; t++) begin
         @(negedge clk);
         exp_in = (t >= 1 && t <= 6);
         total_cnt++;
         if (bus.ds_in_valid !== exp_in) $display("FAIL rr_in_valid t=%0d: got %b want %b", t, bus.ds_in_valid, exp_in);
         else pass_cnt++;
         if (exp_in) begin
            exp_q = ((t - 1) % 2 == 1) ? Q1 : Q0;
            total_cnt++;
            if (bus.ds_query !== exp_q) $display("FAIL rr_query t=%0d: got %h want %h", t, bus.ds_query, exp_q);
            else pass_cnt++;
         end
         g = t - 2 - PIPE_STAGES;
         exp_rsp = (g >= 0 && g <= 5) ? ((g % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         total_cnt++;
         if (bus.rsp_valid !== exp_rsp) $display("FAIL route_rsp_valid t=%0d: got %b want %b", t, bus.rsp_valid, exp_rsp);
         else pass_cnt++;
         if (exp_rsp != 2'b00) begin
            total_cnt++;
            if (bus.rsp_addr_1st !== 3'b010 || bus.rsp_addr_2nd !== 3'b101)
               $display("FAIL route_addr t=%0d: got %b/%b want 010/101", t, bus.rsp_addr_1st, bus.rsp_addr_2nd);
            else pass_cnt++;
         end
         bus.req_valid = (t < 6) ? 2'b11 : 2'b00;
         #1;
         exp_rdy = (t < 6) ? ((t % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         total_cnt++;
         if (bus.req_ready !== exp_rdy) $display("FAIL rr_grant t=%0d: got %b want %b", t, bus.req_ready, exp_rdy);
         else pass_cnt++;
      end
      stub_en = 1'b0;
   endtask

   // Fill the FIFO with no results, then free one slot.
   task automatic test_full;
      logic [1:0] exp_rdy;
      man_a1 = 3'd3; man_a2 = 3'd4;
      for (int u = 0; u < 13; u++) begin
         @(negedge clk);
         if (u == 11) begin
            total_cnt++;
            if (bus.rsp_valid !== 2'b01) $display("FAIL full_rsp_valid: got %b want 01", bus.rsp_valid); else pass_cnt++;
            total_cnt++;
            if (bus.rsp_addr_1st !== 3'd3 || bus.rsp_addr_2nd !== 3'd4)
               $display("FAIL full_rsp_addr: got %0d/%0d want 3/4", bus.rsp_addr_1st, bus.rsp_addr_2nd);
            else pass_cnt++;
         end
         man_ov = (u == 10);
         bus.req_valid = 2'b01;
         #1;
         exp_rdy = (u < 8 || u == 11) ? 2'b01 : 2'b00;
         total_cnt++;
         if (bus.req_ready !== exp_rdy) $display("FAIL full_ready u=%0d: got %b want %b", u, bus.req_ready, exp_rdy);
         else pass_cnt++;
      end
      bus.req_valid = 2'b00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         man_ov = 1'b1;
      end
      @(negedge clk);
      man_ov = 1'b0;
   endtask

   // Three in flight, stop, write attempt in DRAIN, then drain to IDLE.
   task automatic test_stop;
      @(negedge clk);
      cfg_stop = 1'b1; bus.req_valid = 2'b00;
      @(negedge clk);
      cfg_stop = 1'b0; bus.req_valid = 2'b11;
      sv_wr_en = 1'b1; sv_wr_addr = 3'd3; sv_wr_data = 64'hDEAD;
      #1;
      total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL stop_ready: got %b want 00", bus.req_ready); else pass_cnt++;
      @(negedge clk);
      sv_wr_en = 1'b0;
      total_cnt++; if (err_sticky !== 2'b01) $display("FAIL stop_err_wr: got %b want 01", err_sticky); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (w_search[3] !== 64'd3) $display("FAIL stop_bank_kept: got %h want 3", w_search[3]); else pass_cnt++;
      man_a1 = 3'd2; man_a2 = 3'd5;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         man_ov = 1'b1;
         #1;
         total_cnt++;
         if (bus.req_ready !== 2'b00) $display("FAIL drain_ready k=%0d: got %b want 00", k, bus.req_ready); else pass_cnt++;
      end
      @(negedge clk);
      man_ov = 1'b0;
      total_cnt++; if (bus.rsp_valid !== 2'b01) $display("FAIL drain_last_rsp: got %b want 01", bus.rsp_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL idle_ready: got %b want 00", bus.req_ready); else pass_cnt++;
      total_cnt++; if (err_sticky !== 2'b01) $display("FAIL idle_err: got %b want 01", err_sticky); else pass_cnt++;
      total_cnt++; if (issued_cnt !== EXP_ISSUED) $display("FAIL perf_issued: got %0d want %0d", issued_cnt, EXP_ISSUED); else pass_cnt++;
      total_cnt++; if (completed_cnt !== EXP_DONE) $display("FAIL perf_done: got %0d want %0d", completed_cnt, EXP_DONE); else pass_cnt++;
      bus.req_valid = 2'b00;
   endtask

   // Reset while a query is being issued; a stale result afterwards is an error.
   task automatic test_reset_mid;
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; bus.req_valid = 2'b01;
      @(negedge clk);
      total_cnt++; if (bus.ds_in_valid !== 1'b1) $display("FAIL mid_in_valid: got %b want 1", bus.ds_in_valid); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (bus.ds_in_valid !== 1'b0) $display("FAIL mid_rst_in_valid: got %b want 0", bus.ds_in_valid); else pass_cnt++;
      total_cnt++; if (bus.ds_query !== 64'd0) $display("FAIL mid_rst_query: got %h want 0", bus.ds_query); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL mid_rst_ready: got %b want 00", bus.req_ready); else pass_cnt++;
      total_cnt++; if (err_sticky !== 2'b00) $display("FAIL mid_rst_err: got %b want 00", err_sticky); else pass_cnt++;
      total_cnt++; if (w_search[5] !== 64'd0) $display("FAIL mid_rst_search5: got %h want 0", w_search[5]); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1; bus.req_valid = 2'b00;
      @(negedge clk);
      man_ov = 1'b1;
      @(negedge clk);
      man_ov = 1'b0;
      total_cnt++; if (err_sticky !== 2'b10) $display("FAIL late_err: got %b want 10", err_sticky); else pass_cnt++;
      total_cnt++; if (bus.rsp_valid !== 2'b00) $display("FAIL late_rsp_valid: got %b want 00", bus.rsp_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_bank();
      test_rr_and_route();
      test_full();
      test_stop();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
